// File: rtl/uart_rx_wb_if.sv
// rtl/uart_rx_wb_if.sv - Wishbone slave bus slice for the UART receiver
interface uart_rx_wb_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/uart_rx_wb.sv
// rtl/uart_rx_wb.sv - Wishbone UART receiver (8N1) with byte FIFO and level irq
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_wb #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic         wb_clk_i,
   input  logic         wb_rst_n_i,
   uart_rx_wb_if.slave  wbs,
   input  logic         rx_i,
   output logic         irq_o
);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
   localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif

   logic [7:0]  mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic        empty, full;

   logic [2:0]  state;
   logic [15:0] cnt, div_q, clkdiv, div_new;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        push_pend;
   logic [7:0]  push_byte;
   logic        frm_pulse;
   logic        byte_ok;

   logic [2:0]  sync;
   logic        rx_s, fall, expire;

   logic        irqen, ovr_err, frm_err, par_err;
   logic        req, rd_req, wr_req, pop, do_push, ovr_set;
   logic [1:0]  reg_sel;
   logic [31:0] status;

   logic        unused_ok;
   assign unused_ok = &{1'b0, wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                        wbs.wbs_sel_i[3:2], wbs.wbs_dat_i[31:16]};

   assign req     = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~wbs.wbs_ack_o;
   assign rd_req  = req & ~wbs.wbs_we_i;
   assign wr_req  = req & wbs.wbs_we_i;
   assign reg_sel = wbs.wbs_adr_i[3:2];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop on the same edge frees the slot, so a push into a full FIFO is not an overrun.
   assign pop     = rd_req && (reg_sel == 2'd0) && !empty;
   assign do_push = push_pend && (!full || pop);
   assign ovr_set = push_pend && full && !pop;

   assign rx_s   = sync[1];
   assign fall   = sync[2] & ~sync[1];
   assign expire = (cnt <= 16'd1);

   assign status = {27'd0, par_err, frm_err, ovr_err, full, ~empty};

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_pulse;
   assign byte_ok = ~par_bad;
`else
   assign byte_ok = 1'b1;
   assign par_err = 1'b0;
`endif

   always_comb begin
      div_new = clkdiv;
      if (wbs.wbs_sel_i[0]) div_new[7:0]  = wbs.wbs_dat_i[7:0];
      if (wbs.wbs_sel_i[1]) div_new[15:8] = wbs.wbs_dat_i[15:8];
      if (div_new < 16'd2)  div_new = 16'd2;
   end

   always_ff @(posedge wb_clk_i) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_byte;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) sync <= 3'b111;
      else             sync <= {sync[1:0], rx_i};
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state     <= S_IDLE;
         cnt       <= 16'd0;
         div_q     <= DIV_RESET;
         bit_idx   <= 3'd0;
         shift     <= 8'd0;
         push_pend <= 1'b0;
         push_byte <= 8'd0;
         frm_pulse <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad   <= 1'b0;
         par_pulse <= 1'b0;
`endif
      end else begin
         push_pend <= 1'b0;
         frm_pulse <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_pulse <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (fall) begin
                  state <= S_START;
                  cnt   <= {1'b0, clkdiv[15:1]};
                  div_q <= clkdiv;
`ifdef UART_RX_PARITY_EN
                  par_bad <= 1'b0;
`endif
               end
            end
            S_START: begin
               if (expire) begin
                  if (!rx_s) begin
                     state   <= S_DATA;
                     cnt     <= div_q;
                     bit_idx <= 3'd0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (expire) begin
                  shift   <= {rx_s, shift[7:1]};
                  cnt     <= div_q;
                  bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_idx == 3'd7) state <= S_PARITY;
`else
                  if (bit_idx == 3'd7) state <= S_STOP;
`endif
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (expire) begin
                  if (^{shift, rx_s}) begin
                     par_bad   <= 1'b1;
                     par_pulse <= 1'b1;
                  end
                  cnt   <= div_q;
                  state <= S_STOP;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
`endif
            S_STOP: begin
               if (expire) begin
                  if (rx_s) begin
                     push_pend <= byte_ok;
                     push_byte <= shift;
                     state     <= S_IDLE;
                  end else begin
                     frm_pulse <= 1'b1;
                     state     <= S_BREAK;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            S_BREAK: begin
               if (rx_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         wbs.wbs_ack_o <= 1'b0;
         wbs.wbs_dat_o <= 32'd0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         clkdiv        <= DIV_RESET;
         irqen         <= 1'b0;
         ovr_err       <= 1'b0;
         frm_err       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err       <= 1'b0;
`endif
         irq_o         <= 1'b0;
      end else begin
         wbs.wbs_ack_o <= req;
         wbs.wbs_dat_o <= 32'd0;
         if (rd_req) begin
            case (reg_sel)
               2'd0:    wbs.wbs_dat_o <= empty ? 32'd0 : {24'd0, mem[rd_ptr[AW-1:0]]};
               2'd1:    wbs.wbs_dat_o <= status;
               2'd2:    wbs.wbs_dat_o <= {16'd0, clkdiv};
               default: wbs.wbs_dat_o <= {31'd0, irqen};
            endcase
         end
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push) wr_ptr <= wr_ptr + 1'b1;

         // Clears first so that a same-cycle hardware event still leaves the flag set.
         if (wr_req && reg_sel == 2'd1) begin
            if (wbs.wbs_dat_i[2]) ovr_err <= 1'b0;
            if (wbs.wbs_dat_i[3]) frm_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (wbs.wbs_dat_i[4]) par_err <= 1'b0;
`endif
         end
         if (ovr_set)   ovr_err <= 1'b1;
         if (frm_pulse) frm_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
         if (par_pulse) par_err <= 1'b1;
`endif
         if (wr_req && reg_sel == 2'd2) clkdiv <= div_new;
         if (wr_req && reg_sel == 2'd3) irqen  <= wbs.wbs_dat_i[0];
         irq_o <= irqen & ~empty;
      end
   end
endmodule

// File: doc/uart_rx_wb.md
Name: uart_rx_wb

Overview:
- Wishbone-slave UART receiver. Sits directly downstream of the user-area address decode: it consumes the uart_* bus slice and the RX pad bit that the wrapper routes to it.
- Deserialises 8N1 frames from one RX line into a byte FIFO that firmware reads over Wishbone.
- Raises a level interrupt while data is pending.

Parameters:
- FIFO_DEPTH, 8, RX byte FIFO entries; power of two, 2..64.
- DIV_RESET, 16'd868, reset value of CLKDIV in wb_clk_i cycles per bit (115200 baud at 100 MHz).

Ports:
- wb_clk_i  input  1  sole clock
- wb_rst_n_i  input  1  asynchronous active-low reset
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte selects; only sel[0] and sel[1] are honoured, for CLKDIV
- wbs_adr_i  input  32  address; bits [3:2] select the register
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- rx_i  input  1  serial RX line, asynchronous, idle high
- irq_o  output  1  level interrupt

Behaviour:
- Reset (async assert, sync release):
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - FIFO empty, all status flags 0, CLKDIV=DIV_RESET, IRQEN=0, FSM in IDLE.
  - Reset asserted mid-frame discards the partial byte and all FIFO contents.
- Register map (adr[3:2]):
  - 0 RXDATA (RO): read returns {24'd0, head byte} and pops. Read when empty returns 0 and changes nothing.
  - 1 STATUS: bit0 not_empty, bit1 full, bit2 overrun, bit3 frame_err, bit4 parity_err. Bits 2-4 are sticky and write-1-to-clear. Bits 0-1 are read-only.
  - 2 CLKDIV (RW, 16 bits): writes below 2 are stored as 2.
  - 3 CTRL: bit0 IRQEN.
  - Writes to RO fields are ignored.
- Wishbone handshake:
  - ack asserts exactly 1 cycle after a cycle where stb&cyc&!ack, and is held for one cycle.
  - Back-to-back requests therefore get ack every other cycle.
  - wbs_dat_o is valid in the ack cycle; it is 0 when ack=0 or on a write.
  - The pop and the W1C clear take effect on the ack edge.
- RX path:
  - rx_i passes through a 2-flop synchroniser. A falling edge is detected from the synchronised bit; the synchroniser adds 2 cycles of latency.
  - CLKDIV is latched into a private divisor when the START state is entered. A CLKDIV write mid-frame affects only the next frame.
- FSM:
  - IDLE: on falling edge, go to START and load the counter with div/2.
  - START: when the counter expires, sample. If low, go to DATA with counter=div and bit index 0. If high, it was a glitch: go to IDLE.
  - DATA: sample on each expiry, LSB first; after 8 bits go to STOP (or PARITY when the option is enabled).
  - STOP: sample on expiry.
    - If high, push the byte. If the FIFO is full, drop the byte, set overrun, and leave existing contents unchanged.
    - If low, set frame_err, discard the byte, and go to BREAK.
  - BREAK: wait for rx high, then go to IDLE.
- Push timing: a push lands in the cycle after the stop-bit sample, so not_empty is visible on the next read.
- Simultaneous pop and push:
  - When full: both happen, the FIFO stays full, and there is no overrun.
  - When empty: the read returns 0 and the push still lands.
- Pointers are log2(FIFO_DEPTH)+1 bits wide, and the wrap bit distinguishes full from empty.
- irq_o = IRQEN & not_empty, registered with 1 cycle lag.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and expects even parity over the 8 data bits.
  - On mismatch: set parity_err and discard the byte; the frame still proceeds to STOP, where the frame check applies.
  - STATUS bit4 is live.
- Undefined:
  - 8N1 only; DATA goes to STOP.
  - STATUS bit4 reads 0, and writes to it are ignored.

Test Plan:
- Reset defaults:
  - Reset, then read CLKDIV: returns 868 with ack exactly 1 cycle after stb.
  - Read STATUS: returns 0; irq_o=0.
- Single byte:
  - CLKDIV=16, IRQEN=1, drive 0xA5 on rx_i as 8N1.
  - Required: STATUS=0x1 and irq_o=1.
  - Read RXDATA returns 0xA5; afterwards STATUS=0 and irq_o drops 1 cycle later.
- Overrun and wrap:
  - Send 9 bytes 0x00..0x08 with FIFO_DEPTH=8.
  - Required: STATUS=0x7.
  - Reading 8 times returns 0x00..0x07 and the 9th read returns 0.
  - Write 0x4 to STATUS, then read: returns 0.
- Frame error and glitch:
  - Send a byte with stop bit 0, then hold rx low for 40 bit-times.
  - Required: frame_err=1, FIFO empty, and no further frames until rx returns high.
  - A 3-cycle low pulse causes no push and no error.
- Simultaneous full pop/push:
  - Fill the FIFO to 8, then time a RXDATA read ack to coincide with the push of 0x55.
  - Required: overrun=0, still full, and 0x55 is the last of the 8 reads.
- Parity (macro defined):
  - Send 0x03 with parity bit 1.
  - Required: parity_err=1 and FIFO empty.
  - Send 0x03 with parity bit 0: the byte is accepted.
